// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first in bursts of framed repeats.
// Optional macro PARITY_EN appends an even-parity bit to every frame.
module seq_pattern_tx #(
  parameter int unsigned       PAT_W   = 7,
  parameter logic [PAT_W-1:0]  PATTERN = 7'b1010101,
  parameter int unsigned       GAP     = 2,
  parameter int unsigned       CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep,
  input  logic             stop,
  output logic             dout,
  output logic             dout_vld,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = $clog2(PAT_W);
  localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
`ifdef PARITY_EN
  localparam logic PAR_BIT = ^PATTERN;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_PAR, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cont_q, cont_d;
  logic               stop_q, stop_d;
  logic               dout_q, dout_d;
  logic               vld_q, vld_d;
  logic               frame_q, frame_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               frame_end;
  logic               stop_eff;

  // Next state; outputs are derived from the next state so they register alongside it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    cont_d    = cont_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    frame_end = 1'b0;
    stop_eff  = stop_q | stop;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          idx_d   = IDX_TOP;
          cnt_d   = rep;
          cont_d  = (rep == '0);
          stop_d  = stop;
        end
      end
      S_SEND: begin
        if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
`ifdef PARITY_EN
          state_d = S_PAR;
`else
          frame_end = 1'b1;
`endif
        end
      end
      S_PAR: frame_end = 1'b1;
      S_GAP: begin
        if (stop_eff) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_q == '0) begin
          state_d = S_SEND;
          idx_d   = IDX_TOP;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && stop) stop_d = 1'b1;

    // Frame boundary: count the frame, then end the burst or start the next frame.
    if (frame_end) begin
      if (!cont_q) cnt_d = cnt_q - CNT_W'(1);
      if (stop_eff || (!cont_q && cnt_q == CNT_W'(1))) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else if (GAP == 0) begin
        state_d = S_SEND;
        idx_d   = IDX_TOP;
      end else begin
        state_d = S_GAP;
        gap_d   = GAP_TOP;
      end
    end

    if (state_d == S_IDLE) stop_d = 1'b0;

    dout_d  = 1'b0;
    vld_d   = 1'b0;
    frame_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_SEND) begin
      dout_d  = PATTERN[idx_d];
      vld_d   = 1'b1;
      frame_d = (idx_d == IDX_TOP);
    end
`ifdef PARITY_EN
    if (state_d == S_PAR) begin
      dout_d = PAR_BIT;
      vld_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign frame    = frame_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: position-in-burst reference model plus directed literal checks.
module tb_seq_pattern_tx;

  localparam int unsigned PAT_W = 7;
  localparam int unsigned GAP   = 2;
  localparam int unsigned CNT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN = 7'b1010101;
`ifdef PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = PAT_W + PB;
  localparam int P  = FL + GAP;

  logic             clk, rst, start, stop;
  logic [CNT_W-1:0] rep;
  logic             dout, dout_vld, frame, busy, done;

  seq_pattern_tx #(.PAT_W(PAT_W), .PATTERN(PATTERN), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rep(rep), .stop(stop),
    .dout(dout), .dout_vld(dout_vld), .frame(frame), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a burst is k cycles old; frame f = k/P, position pos = k%P.
  bit   m_act = 1'b0;
  int   m_k, m_last, pos, fno;
  logic e_dout, e_vld, e_frame, e_busy, e_done;
  bit   chk_en = 1'b0;
  int   busy_tot = 0, done_tot = 0, frame_tot = 0;
  logic [15:0] bits_sr = '0;

  function automatic logic exp_bit(input int p);
    if (p < PAT_W) return PATTERN[PAT_W-1-p];
    return ^PATTERN;
  endfunction

  always begin
    @(posedge clk);
    e_done = 1'b0;
    if (rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act  = 1'b1;
        m_k    = 0;
        m_last = (rep == '0) ? (1 << 30) : int'(rep) - 1;
        if (stop) m_last = 0;
      end
    end else begin
      pos = m_k % P;
      fno = m_k / P;
      if (stop) begin
        if (pos < FL) begin
          if (fno < m_last) m_last = fno;
        end else begin
          m_act  = 1'b0;
          e_done = 1'b1;
        end
      end
      if (m_act) begin
        if (pos == FL - 1 && fno == m_last) begin
          m_act  = 1'b0;
          e_done = 1'b1;
        end else begin
          m_k++;
        end
      end
    end
    pos = m_k % P;
    e_busy  = m_act;
    e_vld   = m_act && (pos < FL);
    e_dout  = e_vld ? exp_bit(pos) : 1'b0;
    e_frame = m_act && (pos == 0);
    #1;
    if (chk_en) begin
      chk("cyc_dout", int'(dout), int'(e_dout));
      chk("cyc_vld", int'(dout_vld), int'(e_vld));
      chk("cyc_frame", int'(frame), int'(e_frame));
      chk("cyc_busy", int'(busy), int'(e_busy));
      chk("cyc_done", int'(done), int'(e_done));
    end
    if (!rst) begin
      busy_tot  += int'(busy);
      done_tot  += int'(done);
      frame_tot += int'(frame);
      if (dout_vld) bits_sr = {bits_sr[14:0], dout};
    end
  end

  task automatic pulse_start(input int r, input bit s);
    @(negedge clk);
    start = 1'b1;
    rep   = CNT_W'(r);
    stop  = s;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    if (got) chk({nm, "_busy_at_done"}, int'(busy), 0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_tot >= target) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("frame_wait", int'(got), 1);
  endtask

  int b0, d0, f0;
  localparam int EXP_BITS = (PB != 0) ? 8'hAA : 7'h55;

  task automatic snap();
    b0 = busy_tot;
    d0 = done_tot;
    f0 = frame_tot;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; rep = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_frame", int'(frame), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // single frame
    snap();
    pulse_start(1, 1'b0);
    wait_done("t1", 100);
    chk("t1_bits", int'(bits_sr[FL-1:0]), EXP_BITS);
    chk("t1_busy_cycles", busy_tot - b0, FL);
    chk("t1_frames", frame_tot - f0, 1);
    chk("t1_dones", done_tot - d0, 1);

    // three frames with gaps
    repeat (2) @(negedge clk);
    snap();
    pulse_start(3, 1'b0);
    wait_done("t2", 100);
    chk("t2_busy_cycles", busy_tot - b0, (PB != 0) ? 28 : 25);
    chk("t2_frames", frame_tot - f0, 3);
    chk("t2_dones", done_tot - d0, 1);

    // continuous, stop on bit 3 of frame 2
    repeat (2) @(negedge clk);
    snap();
    pulse_start(0, 1'b0);
    wait_frames(f0 + 2, 100);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("t3", 100);
    chk("t3_frames", frame_tot - f0, 2);
    chk("t3_busy_cycles", busy_tot - b0, (PB != 0) ? 18 : 16);

    // start while busy is ignored
    repeat (2) @(negedge clk);
    snap();
    pulse_start(2, 1'b0);
    repeat (2) @(negedge clk);
    pulse_start(5, 1'b0);
    wait_done("t4", 100);
    chk("t4_frames", frame_tot - f0, 2);

    // start and stop together
    repeat (2) @(negedge clk);
    snap();
    pulse_start(3, 1'b1);
    wait_done("t5", 100);
    chk("t5_frames", frame_tot - f0, 1);
    chk("t5_dones", done_tot - d0, 1);

    // async reset mid-frame
    repeat (2) @(negedge clk);
    snap();
    pulse_start(1, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_vld", int'(dout_vld), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_frame", int'(frame), 0);
    chk("t6_async_dout", int'(dout), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_no_done", done_tot - d0, 0);
    snap();
    pulse_start(1, 1'b0);
    wait_done("t6", 100);
    chk("t6_bits", int'(bits_sr[FL-1:0]), EXP_BITS);
    chk("t6_frames", frame_tot - f0, 1);

    // randomized bursts
    for (int it = 0; it < 30; it++) begin
      bit fin = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      pulse_start(int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0));
      for (int c = 0; c < 120; c++) begin
        if (done) begin
          fin = 1'b1;
          break;
        end
        start = ($urandom_range(0, 9) == 0);
        rep   = CNT_W'($urandom_range(0, 15));
        stop  = (c >= 60) || ($urandom_range(0, 29) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b0;
      chk("rand_burst_end", int'(fin), 1);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
